output_mem_controller: RTL and testbench

Receiving end of the PE result interface: collects the four `result_tile/result_address/result_valid` streams from the 2x2 PE array. It accumulates each tile into an on-chip output buffer with per-element saturating read-modify-write. The buffer can be read back through the output scan port once `conv_completed` is seen. It sits beside `main_controller` and the data/weight memory controllers under the controller/PE top.

---
 rtl/output_mem_controller.sv | 244 ++++++++++++++++++++++++
 tb/tb_output_mem_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_mem_controller.sv
`timescale 1ns/1ps
// Output buffer for PE result tiles: four input FIFOs, round-robin arbiter, saturating RMW.
// Latency: valid edge E -> buffer write at edge E+3. Inputs have no backpressure; overflow is flagged.

// Generic synchronous FIFO.
// Latency: a pushed entry is visible at the head one cycle later.
// Backpressure: o_push_rdy low when full; pushes while full are ignored.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push_vld,
  input  logic [W-1:0] i_push_dat,
  output logic         o_push_rdy,
  input  logic         i_pop_rdy,
  output logic         o_pop_vld,
  output logic [W-1:0] o_pop_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;

  assign o_pop_vld  = (r_wr_ptr != r_rd_ptr);
  assign o_push_rdy = (r_wr_ptr[AW-1:0] != r_rd_ptr[AW-1:0]) || (r_wr_ptr[AW] == r_rd_ptr[AW]);
  assign o_pop_dat  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push_vld && o_push_rdy) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop_rdy && o_pop_vld)   r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push_vld && o_push_rdy) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end
endmodule

// Collects four PE result streams and accumulates tiles into the output buffer.
// Latency: enqueue at E, grant in cycle after E, S1 then S2, write commits at E+3.
// Backpressure: none upstream; a full FIFO drops the tile and sets overflow_o.
module output_mem_controller #(
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [5:0][5:0][11:0] result_tile_i_0,
  input  logic signed [5:0][5:0][11:0] result_tile_i_1,
  input  logic signed [5:0][5:0][11:0] result_tile_i_2,
  input  logic signed [5:0][5:0][11:0] result_tile_i_3,
  input  logic [11:0]                 result_address_i_0,
  input  logic [11:0]                 result_address_i_1,
  input  logic [11:0]                 result_address_i_2,
  input  logic [11:0]                 result_address_i_3,
  input  logic                        result_valid_i_0,
  input  logic                        result_valid_i_1,
  input  logic                        result_valid_i_2,
  input  logic                        result_valid_i_3,
  input  logic                        clear_i,
  input  logic                        scan_mode,
  input  logic [ADDR_W-1:0]           scan_addr,
  output logic [511:0]                scan_out,
  output logic                        busy_o,
  output logic                        idle_o,
  output logic                        overflow_o,
  output logic                        addr_err_o
);
  localparam int TW = 432;
  localparam int EW = TW + ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_SWEEP} clr_state_t;

  logic [TW-1:0]     w_tile [4];
  logic [11:0]       w_addr [4];
  logic [3:0]        w_vld;
  logic [3:0]        w_addr_ok;
  logic [3:0]        w_rdy;
  logic [3:0]        w_push;
  logic [3:0]        w_pop;
  logic [3:0]        w_nonempty;
  logic [EW-1:0]     w_fifo_dat [4];
  logic [EW-1:0]     w_head;
  logic              w_gnt_vld;
  logic [1:0]        w_gnt_idx;
  logic              w_block;
  logic              w_pipe_empty;
  logic [TW-1:0]     w_s1_old;
  logic [TW-1:0]     w_s2_sum;
  clr_state_t        r_state;
  clr_state_t        w_state_nxt;
  logic [1:0]        r_ptr;
  logic              r_s1_vld;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [TW-1:0]     r_s1_tile;
  logic              r_s2_vld;
  logic [ADDR_W-1:0] r_s2_addr;
  logic [TW-1:0]     r_s2_old;
  logic [TW-1:0]     r_s2_new;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_ovf;
  logic              r_aerr;
  logic [511:0]      r_scan;
  logic [TW-1:0]     r_mem [DEPTH];

  assign w_tile[0] = result_tile_i_0;
  assign w_tile[1] = result_tile_i_1;
  assign w_tile[2] = result_tile_i_2;
  assign w_tile[3] = result_tile_i_3;
  assign w_addr[0] = result_address_i_0;
  assign w_addr[1] = result_address_i_1;
  assign w_addr[2] = result_address_i_2;
  assign w_addr[3] = result_address_i_3;
  assign w_vld     = {result_valid_i_3, result_valid_i_2, result_valid_i_1, result_valid_i_0};

  for (genvar g = 0; g < 4; g++) begin : g_in
    assign w_addr_ok[g] = (w_addr[g][11:ADDR_W] == '0);
    assign w_push[g]    = w_vld[g] && w_addr_ok[g];
    assign w_pop[g]     = w_gnt_vld && (w_gnt_idx == 2'(g));

    fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push_vld (w_push[g]),
      .i_push_dat ({w_addr[g][ADDR_W-1:0], w_tile[g]}),
      .o_push_rdy (w_rdy[g]),
      .i_pop_rdy  (w_pop[g]),
      .o_pop_vld  (w_nonempty[g]),
      .o_pop_dat  (w_fifo_dat[g])
    );
  end

  // Grants stop as soon as a clear is requested so the pipeline can drain.
  assign w_block      = (r_state != ST_IDLE) || clear_i;
  assign w_pipe_empty = !r_s1_vld && !r_s2_vld;

  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = r_ptr + 2'(k);
      if (w_nonempty[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = idx;
      end
    end
    if (w_block) w_gnt_vld = 1'b0;
  end

  assign w_head = w_fifo_dat[w_gnt_idx];

  function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {a[11], a} + {b[11], b};
    if (s[12] != s[11]) return s[12] ? 12'h800 : 12'h7FF;
    return s[11:0];
  endfunction

  // Forward the in-flight sum so back-to-back updates to one word accumulate.
  assign w_s1_old = (r_s2_vld && (r_s2_addr == r_s1_addr)) ? w_s2_sum : r_mem[r_s1_addr];

  always_comb begin
    w_s2_sum = '0;
    for (int i = 0; i < 36; i++) begin
      w_s2_sum[i*12 +: 12] = sat_add(r_s2_old[i*12 +: 12], r_s2_new[i*12 +: 12]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_ptr    <= '0;
    end else begin
      r_s1_vld <= w_gnt_vld;
      r_s2_vld <= r_s1_vld;
      if (w_gnt_vld) r_ptr <= w_gnt_idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    r_s1_addr <= w_head[EW-1:TW];
    r_s1_tile <= w_head[TW-1:0];
    r_s2_addr <= r_s1_addr;
    r_s2_old  <= w_s1_old;
    r_s2_new  <= r_s1_tile;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (clear_i) w_state_nxt = w_pipe_empty ? ST_SWEEP : ST_PEND;
      ST_PEND:  if (w_pipe_empty) w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (r_clr_addr == ADDR_W'(DEPTH-1)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_clr_addr <= '0;
    else       r_clr_addr <= (r_state == ST_SWEEP && w_state_nxt == ST_SWEEP) ? r_clr_addr + ADDR_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_SWEEP) r_mem[r_clr_addr] <= '0;
      else if (r_s2_vld)       r_mem[r_s2_addr]  <= w_s2_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf  <= 1'b0;
      r_aerr <= 1'b0;
      r_scan <= '0;
    end else begin
      if (|(w_vld & ~w_rdy))     r_ovf  <= 1'b1;
      if (|(w_vld & ~w_addr_ok)) r_aerr <= 1'b1;
      if (scan_mode)             r_scan <= {{(512-TW){1'b0}}, r_mem[scan_addr]};
    end
  end

  assign scan_out   = r_scan;
  assign busy_o     = (r_state == ST_SWEEP);
  assign idle_o     = !w_nonempty[0] && !w_nonempty[1] && !w_nonempty[2] && !w_nonempty[3]
                      && w_pipe_empty && (r_state == ST_IDLE);
  assign overflow_o = r_ovf;
  assign addr_err_o = r_aerr;
endmodule

// File: tb/tb_output_mem_controller.sv
`timescale 1ns/1ps
// Directed bench for output_mem_controller with a queue/array model of the output buffer.
module tb_output_mem_controller;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [431:0] tb_tile [4];
  logic [11:0]  tb_addr [4];
  logic [3:0]   tb_vld = '0;
  logic         clear_i = 1'b0;
  logic         scan_mode = 1'b0;
  logic [7:0]   scan_addr = '0;
  logic [511:0] scan_out;
  logic         busy_o, idle_o, overflow_o, addr_err_o;

  always #5 clk = ~clk;

  output_mem_controller dut (
    .clk(clk), .reset(reset),
    .result_tile_i_0(tb_tile[0]), .result_tile_i_1(tb_tile[1]),
    .result_tile_i_2(tb_tile[2]), .result_tile_i_3(tb_tile[3]),
    .result_address_i_0(tb_addr[0]), .result_address_i_1(tb_addr[1]),
    .result_address_i_2(tb_addr[2]), .result_address_i_3(tb_addr[3]),
    .result_valid_i_0(tb_vld[0]), .result_valid_i_1(tb_vld[1]),
    .result_valid_i_2(tb_vld[2]), .result_valid_i_3(tb_vld[3]),
    .clear_i(clear_i), .scan_mode(scan_mode), .scan_addr(scan_addr),
    .scan_out(scan_out), .busy_o(busy_o), .idle_o(idle_o),
    .overflow_o(overflow_o), .addr_err_o(addr_err_o)
  );

  // Model state: buffer contents, accepted tiles per input, arbiter pointer, flags.
  typedef struct {
    logic [7:0]   a;
    logic [431:0] t;
  } ent_t;

  logic [431:0] exp_mem [256];
  ent_t         mq [4][$];
  int           m_ptr = 0;
  int           m_busy_left = 0;
  logic         m_ovf = 1'b0;
  logic         m_aerr = 1'b0;
  logic [511:0] m_scan_exp = '0;
  logic         m_chk = 1'b0;
  int           n_chk = 0;
  int           n_err = 0;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [431:0] fill(input int v);
    logic [431:0] r;
    for (int i = 0; i < 36; i++) r[i*12 +: 12] = v[11:0];
    return r;
  endfunction

  function automatic logic [431:0] add_t(input logic [431:0] a, input logic [431:0] b);
    logic [431:0] r;
    int s;
    for (int i = 0; i < 36; i++) begin
      s = int'($signed(a[i*12 +: 12])) + int'($signed(b[i*12 +: 12]));
      if (s > 2047) s = 2047;
      if (s < -2048) s = -2048;
      r[i*12 +: 12] = s[11:0];
    end
    return r;
  endfunction

  // Apply every accepted tile in round-robin order over the input queues.
  task automatic model_drain();
    int idx;
    ent_t e;
    while (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() > 0) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (mq[idx].size() > 0) break;
      end
      e = mq[idx].pop_front();
      exp_mem[e.a] = add_t(exp_mem[e.a], e.t);
      m_ptr = (idx + 1) % 4;
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < 4; g++) mq[g].delete();
    m_ptr = 0; m_busy_left = 0; m_ovf = 1'b0; m_aerr = 1'b0; m_scan_exp = '0;
  endtask

  always @(posedge clk) if (m_busy_left > 0) m_busy_left = m_busy_left - 1;

  always @(negedge clk) begin
    if (m_chk) begin
      chk("busy_o", 512'(busy_o), 512'(m_busy_left > 0));
      chk("overflow_o", 512'(overflow_o), 512'(m_ovf));
      chk("addr_err_o", 512'(addr_err_o), 512'(m_aerr));
      chk("scan_out", scan_out, m_scan_exp);
    end
  end

  // Drive valids for one edge; tb_tile/tb_addr must be set beforehand.
  task automatic pulse(input logic [3:0] m);
    ent_t e;
    tb_vld = m;
    @(posedge clk); #1;
    for (int g = 0; g < 4; g++) begin
      if (m[g]) begin
        if (mq[g].size() >= 4) m_ovf = 1'b1;
        if (tb_addr[g][11:8] != 4'd0) m_aerr = 1'b1;
        else if (mq[g].size() < 4) begin
          e.a = tb_addr[g][7:0];
          e.t = tb_tile[g];
          mq[g].push_back(e);
        end
      end
    end
    tb_vld = '0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    m_busy_left = 256;
    for (int i = 0; i < 256; i++) exp_mem[i] = '0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (idle_o !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) chk({nm, "_idle_timeout"}, 512'(idle_o), 512'(1));
    model_drain();
  endtask

  task automatic scan(input logic [7:0] a);
    scan_mode = 1'b1;
    scan_addr = a;
    @(posedge clk); #1;
    scan_mode = 1'b0;
    m_scan_exp = {80'b0, exp_mem[a]};
  endtask

  task automatic set_in(input int g, input logic [431:0] t, input logic [11:0] a);
    tb_tile[g] = t;
    tb_addr[g] = a;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [431:0] v;
    logic [431:0] s20, s200;
    for (int g = 0; g < 4; g++) set_in(g, '0, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    m_chk = 1'b1;
    chk("rst_idle", 512'(idle_o), 512'(1));
    chk("rst_scan", scan_out, '0);

    // Clear sweep length and zeroed contents.
    do_clear();
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy_o) cnt++;
      else break;
    end
    chk("busy_cycles", 512'(cnt), 512'(256));
    @(posedge clk); #1;
    scan(8'd0); scan(8'd255); scan(8'd17);
    chk("clr_addr17", scan_out, '0);

    // Back-to-back accumulate to one word exercises forwarding.
    set_in(0, fill(5), 12'd3);  pulse(4'b0001);
    set_in(0, fill(-2), 12'd3); pulse(4'b0001);
    wait_idle("acc");
    scan(8'd3);
    chk("acc_addr3", scan_out, {80'b0, fill(3)});

    // Four simultaneous tiles; idle returns six edges after the valid edge.
    set_in(0, fill(1), 12'd1); set_in(1, fill(2), 12'd1);
    set_in(2, fill(3), 12'd2); set_in(3, fill(4), 12'd2);
    pulse(4'b1111);
    @(negedge clk);
    chk("four_idle_n1", 512'(idle_o), 512'(0));
    repeat (5) @(negedge clk);
    chk("four_idle_n6", 512'(idle_o), 512'(0));
    @(negedge clk);
    chk("four_idle_n7", 512'(idle_o), 512'(1));
    @(posedge clk); #1;
    wait_idle("four");
    scan(8'd1);
    chk("four_addr1", scan_out, {80'b0, fill(3)});
    scan(8'd2);
    chk("four_addr2", scan_out, {80'b0, fill(7)});

    // Saturation at both rails.
    set_in(0, fill(2000), 12'd9); pulse(4'b0001); wait_idle("sat_pre");
    set_in(0, fill(100), 12'd9);  pulse(4'b0001); wait_idle("sat_pos");
    scan(8'd9);
    chk("sat_pos", scan_out, {80'b0, fill(2047)});
    set_in(1, fill(-2048), 12'd10); pulse(4'b0010); pulse(4'b0010); wait_idle("sat_neg");
    scan(8'd10);
    chk("sat_neg", scan_out, {80'b0, fill(-2048)});
    for (int i = 0; i < 36; i++) begin
      cnt = i - 18;
      v[i*12 +: 12] = cnt[11:0];
    end
    set_in(2, v, 12'd11); pulse(4'b0100); wait_idle("pack");
    scan(8'd11);
    chk("pack_r1c2", 512'(scan_out[8*12 +: 12]), 512'(12'hFF6));
    chk("pack_pad", 512'(scan_out[511:432]), '0);

    // Overflow: five all-valid cycles while the sweep blocks the arbiter.
    do_clear();
    repeat (2) begin @(posedge clk); #1; end
    for (int g = 0; g < 4; g++) set_in(g, fill(g + 1), 12'(30 + g));
    repeat (5) pulse(4'b1111);
    chk("ovf_flag", 512'(overflow_o), 512'(1));
    wait_idle("ovf");
    scan(8'd30);
    chk("ovf_addr30", scan_out, {80'b0, fill(4)});
    scan(8'd33);
    chk("ovf_addr33", scan_out, {80'b0, fill(16)});

    // Upper address bits set: dropped, word 0 untouched.
    set_in(2, fill(9), 12'h100); pulse(4'b0100);
    repeat (4) begin @(posedge clk); #1; end
    chk("aerr_flag", 512'(addr_err_o), 512'(1));
    scan(8'd0);
    chk("aerr_addr0", scan_out, '0);

    // Reset during a sweep with a non-empty FIFO.
    set_in(0, fill(2000), 12'd20); set_in(1, fill(77), 12'd200);
    pulse(4'b0011); wait_idle("pre_rst");
    s20 = exp_mem[20]; s200 = exp_mem[200];
    do_clear();
    repeat (3) begin @(posedge clk); #1; end
    set_in(3, fill(5), 12'd200); pulse(4'b1000); pulse(4'b1000);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    exp_mem[20] = s20; exp_mem[200] = s200;
    chk("mid_busy", 512'(busy_o), '0);
    chk("mid_idle", 512'(idle_o), 512'(1));
    chk("mid_ovf", 512'(overflow_o), '0);
    chk("mid_aerr", 512'(addr_err_o), '0);
    chk("mid_scan", scan_out, '0);

    // After reset PE0 wins: 2000+100 saturates to 2047, then -100 gives 1947.
    set_in(0, fill(100), 12'd20); set_in(1, fill(-100), 12'd20);
    pulse(4'b0011); wait_idle("ptr");
    scan(8'd20);
    chk("ptr_addr20", scan_out, {80'b0, fill(1947)});
    scan(8'd200);
    chk("rst_flush_200", scan_out, {80'b0, fill(77)});

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
